// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline boundary register. It provides DEPTH
//                stages of {valid, instruction, data, ctrl} with stall (hold),
//                flush (bubble injection), control masking on invalid slots
//                and a saturating count of emitted bubble cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter int                DEPTH       = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_in,
  input  logic [31:0]       Instruction_in,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [CTRL_W-1:0] Ctrl_in,
  output logic              Valid_out,
  output logic [31:0]       Instruction_out,
  output logic [DATA_W-1:0] Data_out,
  output logic [CTRL_W-1:0] Ctrl_out,
  output logic [15:0]       BubbleCount
);

  localparam logic [15:0] c_bcnt_max  = 16'hFFFF;
  localparam logic [31:0] c_instr_nop = 32'h0000_0000;

  // Reject unsupported depths when the design is elaborated.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("pipe_stage_reg: DEPTH must be in the range 1..4");
    end
  endgenerate

  // Stage storage; index DEPTH-1 is the stage that drives the outputs.
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       instr_d [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];
  logic [15:0]       bcnt_q;
  logic [15:0]       bcnt_d;

  // Next-state of the stage chain: flush beats stall, stall beats advance.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      instr_d[i] = instr_q[i];
      data_d[i]  = data_q[i];
      ctrl_d[i]  = ctrl_q[i];
    end
    if (Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
        instr_d[i] = c_instr_nop;
        data_d[i]  = '0;
        ctrl_d[i]  = BUBBLE_CTRL;
      end
    end else if (!Stall) begin
      // An empty slot keeps its data but never carries an opcode or controls.
      valid_d[0] = Valid_in;
      instr_d[0] = Valid_in ? Instruction_in : c_instr_nop;
      data_d[0]  = Data_in;
      ctrl_d[0]  = Valid_in ? Ctrl_in : BUBBLE_CTRL;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        instr_d[i] = instr_q[i-1];
        data_d[i]  = data_q[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
      end
    end
  end

  // Bubble counter: counts non-stalled edges with an empty output slot, no wrap.
  always_comb begin
    bcnt_d = bcnt_q;
    if (!Stall && !valid_q[DEPTH-1] && (bcnt_q != c_bcnt_max)) begin
      bcnt_d = bcnt_q + 16'd1;
    end
  end

  // State registers with synchronous reset to an all-bubble pipeline.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        instr_q[i] <= c_instr_nop;
        data_q[i]  <= '0;
        ctrl_q[i]  <= BUBBLE_CTRL;
      end
      bcnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        instr_q[i] <= instr_d[i];
        data_q[i]  <= data_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
      bcnt_q <= bcnt_d;
    end
  end

  assign Valid_out       = valid_q[DEPTH-1];
  assign Instruction_out = instr_q[DEPTH-1];
  assign Data_out        = data_q[DEPTH-1];
  // Controls are masked so an invalid slot can never raise a write enable.
  assign Ctrl_out        = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : BUBBLE_CTRL;
  assign BubbleCount     = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg at DEPTH 1, 2 and 3
//                sharing one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam logic [7:0] c_bub = 8'hA0;

  logic        clk = 1'b0;
  logic        rst, stall, flush, vin;
  logic [31:0] iin, din;
  logic [7:0]  cin;

  logic        vo   [1:3];
  logic [31:0] io   [1:3];
  logic [31:0] dato [1:3];
  logic [7:0]  co   [1:3];
  logic [15:0] bco  [1:3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .BUBBLE_CTRL(c_bub)) u_d1 (
    .Clk(clk), .Reset(rst), .Stall(stall), .Flush(flush), .Valid_in(vin),
    .Instruction_in(iin), .Data_in(din), .Ctrl_in(cin),
    .Valid_out(vo[1]), .Instruction_out(io[1]), .Data_out(dato[1]),
    .Ctrl_out(co[1]), .BubbleCount(bco[1]));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .BUBBLE_CTRL(c_bub)) u_d2 (
    .Clk(clk), .Reset(rst), .Stall(stall), .Flush(flush), .Valid_in(vin),
    .Instruction_in(iin), .Data_in(din), .Ctrl_in(cin),
    .Valid_out(vo[2]), .Instruction_out(io[2]), .Data_out(dato[2]),
    .Ctrl_out(co[2]), .BubbleCount(bco[2]));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .BUBBLE_CTRL(c_bub)) u_d3 (
    .Clk(clk), .Reset(rst), .Stall(stall), .Flush(flush), .Valid_in(vin),
    .Instruction_in(iin), .Data_in(din), .Ctrl_in(cin),
    .Valid_out(vo[3]), .Instruction_out(io[3]), .Data_out(dato[3]),
    .Ctrl_out(co[3]), .BubbleCount(bco[3]));

  typedef struct {
    logic        st;
    logic        fl;
    logic        v;
    logic [31:0] i;
    logic [31:0] dt;
    logic [7:0]  c;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic [15:0] ebc;
  } vec_t;

  typedef struct {
    int          d;
    logic [31:0] i;
    logic [31:0] dt;
    logic [7:0]  c;
    int          due;
  } sb_t;

  vec_t tbl [10];
  sb_t  sbq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic s, input logic f, input logic v,
                       input logic [31:0] i, input logic [31:0] dt, input logic [7:0] c);
    stall = s; flush = f; vin = v; iin = i; din = dt; cin = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_bubble(input int d, input string tag);
    chk($sformatf("%s_d%0d_valid", tag, d), {63'b0, vo[d]}, 64'd0);
    chk($sformatf("%s_d%0d_instr", tag, d), {32'b0, io[d]}, 64'd0);
    chk($sformatf("%s_d%0d_ctrl", tag, d), {56'b0, co[d]}, {56'b0, c_bub});
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);

    // ---------------- Reset held 2 cycles with a valid input present
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h8C220004, 32'h44, 8'h05);
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int d = 1; d <= 3; d++) begin
        chk_bubble(d, "rst");
        chk($sformatf("rst_d%0d_data", d), {32'b0, dato[d]}, 64'd0);
        chk($sformatf("rst_d%0d_bc", d), {48'b0, bco[d]}, 64'd0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) vin = 1'b0;
      for (int d = 1; d <= 3; d++) begin
        chk($sformatf("lat_k%0d_d%0d_valid", k, d), {63'b0, vo[d]}, {63'b0, (k == d)});
        if (k == d) chk($sformatf("lat_d%0d_instr", d), {32'b0, io[d]}, 64'h8C220004);
      end
    end

    // ---------------- Table-driven single-stage vectors
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h00221820, 32'h11, 8'h05, 1'b1, 32'h00221820, 32'h11, 8'h05, 16'd1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h8C430008, 32'h22, 8'h05, 1'b1, 32'h8C430008, 32'h22, 8'h05, 16'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'hAC640000, 32'h33, 8'h05, 1'b1, 32'h8C430008, 32'h22, 8'h05, 16'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hAC640000, 32'h33, 8'h05, 1'b1, 32'hAC640000, 32'h33, 8'h05, 16'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h55, 8'hFF, 1'b0, 32'h0, 32'h55, c_bub, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 32'h66, 8'h05, 1'b0, 32'h0, 32'h0, c_bub, 16'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 32'h66, 8'h05, 1'b1, 32'h12345678, 32'h66, 8'h05, 16'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h77, 8'h03, 1'b0, 32'h0, 32'h0, c_bub, 16'd2};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h99999999, 32'h99, 8'hFF, 1'b0, 32'h0, 32'h0, c_bub, 16'd2};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h22222222, 32'h88, 8'h0C, 1'b1, 32'h22222222, 32'h88, 8'h0C, 16'd3};
    do_reset();
    for (int n = 0; n < 10; n++) begin
      drive(tbl[n].st, tbl[n].fl, tbl[n].v, tbl[n].i, tbl[n].dt, tbl[n].c);
      tick();
      chk($sformatf("tbl%0d_valid", n), {63'b0, vo[1]}, {63'b0, tbl[n].ev});
      chk($sformatf("tbl%0d_instr", n), {32'b0, io[1]}, {32'b0, tbl[n].ei});
      chk($sformatf("tbl%0d_data", n), {32'b0, dato[1]}, {32'b0, tbl[n].ed});
      chk($sformatf("tbl%0d_ctrl", n), {56'b0, co[1]}, {56'b0, tbl[n].ec});
      chk($sformatf("tbl%0d_bc", n), {48'b0, bco[1]}, {48'b0, tbl[n].ebc});
    end

    // ---------------- Scoreboarded pass-through at DEPTH 1, 2, 3
    do_reset();
    begin
      logic [31:0] s_i [3];
      logic [31:0] s_d [3];
      int          nval [1:3];
      s_i[0] = 32'h00221820; s_i[1] = 32'h8C430008; s_i[2] = 32'hAC640000;
      s_d[0] = 32'h11;       s_d[1] = 32'h22;       s_d[2] = 32'h33;
      for (int d = 1; d <= 3; d++) nval[d] = 0;
      for (int n = 0; n < 8; n++) begin
        if (n < 3) begin
          drive(1'b0, 1'b0, 1'b1, s_i[n], s_d[n], 8'h05);
          for (int d = 1; d <= 3; d++) sbq.push_back('{d, s_i[n], s_d[n], 8'h05, cyc + d});
        end else begin
          drive(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 8'hFF);
        end
        tick();
        for (int d = 1; d <= 3; d++) begin
          if (vo[d]) begin
            int idx;
            idx = -1;
            for (int q = 0; q < sbq.size(); q++) begin
              if (idx < 0 && sbq[q].d == d) idx = q;
            end
            nval[d]++;
            if (idx < 0) begin
              chk($sformatf("sb_d%0d_unexpected", d), 64'd1, 64'd0);
            end else begin
              chk($sformatf("sb_d%0d_instr", d), {32'b0, io[d]}, {32'b0, sbq[idx].i});
              chk($sformatf("sb_d%0d_data", d), {32'b0, dato[d]}, {32'b0, sbq[idx].dt});
              chk($sformatf("sb_d%0d_ctrl", d), {56'b0, co[d]}, {56'b0, sbq[idx].c});
              chk($sformatf("sb_d%0d_when", d), 64'(cyc), 64'(sbq[idx].due));
              sbq.delete(idx);
            end
          end else begin
            chk($sformatf("sb_d%0d_mask_instr", d), {32'b0, io[d]}, 64'd0);
            chk($sformatf("sb_d%0d_mask_ctrl", d), {56'b0, co[d]}, {56'b0, c_bub});
          end
        end
      end
      chk("sb_leftover", 64'(sbq.size()), 64'd0);
      for (int d = 1; d <= 3; d++) chk($sformatf("sb_d%0d_nvalid", d), 64'(nval[d]), 64'd3);
    end

    // ---------------- Stall at DEPTH 2 while A sits at the output
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hA0A0A0A0, 32'hA, 8'h01); tick();
    drive(1'b0, 1'b0, 1'b1, 32'hB0B0B0B0, 32'hB, 8'h02); tick();
    chk("stl_e2_instr", {32'b0, io[2]}, 64'hA0A0A0A0);
    chk("stl_e2_bc", {48'b0, bco[2]}, 64'd2);
    drive(1'b1, 1'b0, 1'b1, 32'hC0C0C0C0, 32'hC, 8'h03);
    for (int k = 3; k <= 4; k++) begin
      tick();
      chk($sformatf("stl_e%0d_valid", k), {63'b0, vo[2]}, 64'd1);
      chk($sformatf("stl_e%0d_instr", k), {32'b0, io[2]}, 64'hA0A0A0A0);
      chk($sformatf("stl_e%0d_bc", k), {48'b0, bco[2]}, 64'd2);
    end
    stall = 1'b0; tick();
    chk("stl_e5_instr", {32'b0, io[2]}, 64'hB0B0B0B0);
    chk("stl_e5_data", {32'b0, dato[2]}, 64'hB);
    vin = 1'b0; tick();
    chk("stl_e6_instr", {32'b0, io[2]}, 64'hC0C0C0C0);
    chk("stl_e6_ctrl", {56'b0, co[2]}, 64'h03);
    tick();
    chk("stl_e7_valid", {63'b0, vo[2]}, 64'd0);
    chk("stl_e7_bc", {48'b0, bco[2]}, 64'd2);

    // ---------------- Flush and Stall together at DEPTH 3
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h01010101, 32'h1, 8'h05); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h02020202, 32'h2, 8'h05); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h03030303, 32'h3, 8'h05); tick();
    chk("fl_pre_valid", {63'b0, vo[3]}, 64'd1);
    chk("fl_pre_instr", {32'b0, io[3]}, 64'h01010101);
    chk("fl_pre_bc", {48'b0, bco[3]}, 64'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h04040404, 32'h4, 8'h05); tick();
    chk_bubble(3, "fl_edge");
    chk("fl_edge_bc", {48'b0, bco[3]}, 64'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("fl_post%0d_valid", k), {63'b0, vo[3]}, 64'd0);
      chk($sformatf("fl_post%0d_bc", k), {48'b0, bco[3]}, 64'(3 + k));
    end

    // ---------------- Bubble counter saturation
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 8'hFF);
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (n == 65534) chk("sat_fffe", {48'b0, bco[1]}, 64'hFFFE);
      if (n == 65535) chk("sat_ffff", {48'b0, bco[1]}, 64'hFFFF);
    end
    for (int d = 1; d <= 3; d++) chk($sformatf("sat_hold_d%0d", d), {48'b0, bco[d]}, 64'hFFFF);
    do_reset();
    for (int d = 1; d <= 3; d++) chk($sformatf("sat_rst_d%0d", d), {48'b0, bco[d]}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register. It generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It adds a valid bit, stall (hold), flush (bubble injection), configurable depth, and a saturating bubble counter. Every stage boundary of the 5-stage MIPS pipeline instantiates it, with widths set per boundary.

Parameters:
DATA_W, 32, width of the datapath payload (ALU result, memory read data, register operands, concatenated by the instantiator)
CTRL_W, 8, width of the control payload (MemtoReg, RegWrite, RegDst, etc., concatenated)
DEPTH, 1, number of register stages in series; legal range 1..4
BUBBLE_CTRL, 0, value loaded into the control payload on reset/flush (must encode RegWrite=0, MemWrite=0)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold all stages this cycle
Flush  in  1  replace all stages with bubbles this cycle
Valid_in  in  1  incoming slot carries a real instruction
Instruction_in  in  32  instruction word
Data_in  in  DATA_W  datapath payload
Ctrl_in  in  CTRL_W  control payload
Valid_out  out  1  last stage holds a real instruction
Instruction_out  out  32  last-stage instruction
Data_out  out  DATA_W  last-stage datapath payload
Ctrl_out  out  CTRL_W  last-stage control payload, forced to BUBBLE_CTRL whenever Valid_out=0
BubbleCount  out  16  saturating count of bubble cycles emitted

Behaviour:
- Clocking: one clock (Clk); reset is synchronous and active-high (Reset). All state updates on the rising edge of Clk only. No other always-sensitivities.
- Storage: DEPTH stages, s[0]..s[DEPTH-1]. Each stage holds {valid, instruction, data, ctrl}. Outputs are driven from s[DEPTH-1]. Latency is DEPTH cycles from input to output.
- Priority per edge: Reset > Flush > Stall > advance.
- Reset (sampled high):
  - all stages: valid=0, instruction=32'h0, data=0, ctrl=BUBBLE_CTRL
  - BubbleCount=0
  - Outputs after the edge: Valid_out=0, Instruction_out=0, Data_out=0, Ctrl_out=BUBBLE_CTRL, BubbleCount=0.
- Flush (Reset low):
  - all stages load the bubble value (same as reset except BubbleCount)
  - the Valid_in slot is discarded
  - Flush with Stall: Flush wins.
- Stall (Reset and Flush low): every stage holds its value; input is ignored; the upstream stage is responsible for holding its inputs.
- Advance (none of the above):
  - s[0] <= inputs
  - s[i] <= s[i-1] for i >= 1
  - if Valid_in=0, s[0] stores instruction=0 and ctrl=BUBBLE_CTRL regardless of Instruction_in/Ctrl_in; data is stored as presented.
- Output masking: Ctrl_out = Valid_out ? s[DEPTH-1].ctrl : BUBBLE_CTRL (combinational). An invalid slot can never assert a write enable.
- BubbleCount:
  - increments by 1 on each edge where Reset=0, Stall=0 and Valid_out=0 (before the edge)
  - saturates at 16'hFFFF with no wrap
  - holds during Stall; unaffected by Flush (a flush only creates the bubbles that are counted later)
- Reset mid-operation: in-flight valid slots are lost; no partial state is retained.
- DEPTH outside 1..4 is a configuration error; the implementation flags it with a generate-time check.
- No combinational path from any input to Valid_out, Instruction_out or Data_out.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with Valid_in=1, Instruction_in=32'h8C220004 -> Valid_out=0, Instruction_out=0, Ctrl_out=BUBBLE_CTRL, BubbleCount=0; after release the first valid output appears DEPTH cycles later.
- Pass-through (DEPTH=1, then 3):
  - Stimulus: stream instructions 32'h00221820, 32'h8C430008, 32'hAC640000 with Data 32'h11, 32'h22, 32'h33 and Ctrl 8'h05 on consecutive cycles.
  - Required: identical sequence at the outputs, delayed exactly 1 or 3 cycles; Valid_out=1 for 3 cycles.
- Stall:
  - Stimulus: DEPTH=2, stream A, B, C; assert Stall for 2 cycles while A is at the output.
  - Required: A held on the output for 3 cycles total, B then C follow with none dropped or duplicated; BubbleCount unchanged during the stall.
- Flush and Stall together:
  - Stimulus: DEPTH=3, all stages valid, assert Flush=1 and Stall=1 for one edge.
  - Required: next cycle Valid_out=0, Ctrl_out=BUBBLE_CTRL, Instruction_out=0; the 3 following cycles are bubbles and BubbleCount rises by 3.
- Invalid input masking: Valid_in=0 with Ctrl_in=8'hFF, Instruction_in=32'hDEADBEEF -> at the output, Valid_out=0, Ctrl_out=BUBBLE_CTRL, Instruction_out=0.
- Counter saturation: force 70000 bubble cycles -> BubbleCount stops at 16'hFFFF and stays there; Reset returns it to 0.
